// File: rtl/scarv_cop_rng_seeder_pkg.sv
// rtl/scarv_cop_rng_seeder_pkg.sv - shared constants and helpers for the RNG seed producer
package scarv_cop_rng_seeder_pkg;

  // Seeder FSM encodings; kept as plain constants so legacy code can match on them.
  localparam logic [1:0] SCARV_COP_RNG_SEED_ST_WARMUP = 2'd0;
  localparam logic [1:0] SCARV_COP_RNG_SEED_ST_RUN    = 2'd1;
  localparam logic [1:0] SCARV_COP_RNG_SEED_ST_FAIL   = 2'd2;

  localparam int SEED_WIDTH  = 32;
  localparam int LEVEL_WIDTH = 5;

  // True on the cycle that accepts the 32nd bit of a word.
  function automatic logic word_done(input logic accept, input logic [4:0] bit_cnt);
    return accept && (bit_cnt == 5'd31);
  endfunction

endpackage

// File: rtl/scarv_cop_rng_seeder_if.sv
// rtl/scarv_cop_rng_seeder_if.sv - seed word valid/ready channel towards the RNG
interface scarv_cop_rng_seeder_if;
  logic        seed_valid;
  logic [31:0] seed_data;
  logic        seed_ready;

  modport master (output seed_valid, output seed_data, input seed_ready);
  modport slave  (input seed_valid, input seed_data, output seed_ready);
endinterface

// File: rtl/scarv_cop_rng_fifo.sv
// rtl/scarv_cop_rng_fifo.sv - small synchronous FIFO with flush, used to buffer seed words
module scarv_cop_rng_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [4:0]       level,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [4:0]       count;
  logic             do_pop;
  logic             do_push;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  assign full  = (count == DEPTH_L);
  assign empty = (count == 5'd0);
  assign level = count;
  assign head  = mem[rd_ptr];

  // Pointer and occupancy tracking; flush discards everything at once.
  always_ff @(posedge g_clk) begin
    if (!g_resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge g_clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/scarv_cop_rng_seeder.sv
// rtl/scarv_cop_rng_seeder.sv - entropy packer, repetition health test and seed FIFO front end
module scarv_cop_rng_seeder
  import scarv_cop_rng_seeder_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int REP_LIMIT    = 16,
  parameter int WARMUP_WORDS = 2
) (
  input  logic                   g_clk,
  input  logic                   g_resetn,
  input  logic                   ent_valid,
  input  logic                   ent_bit,
  input  logic                   health_clr,
  output logic                   health_fail,
  output logic [LEVEL_WIDTH-1:0] fifo_level,
  scarv_cop_rng_seeder_if.master seed
);

  localparam logic [7:0] REP_MAX   = 8'(REP_LIMIT);
  localparam logic [3:0] WARM_LAST = (WARMUP_WORDS == 0) ? 4'd0 : 4'(WARMUP_WORDS - 1);

  logic [1:0]            state;
  logic [1:0]            state_nx;
  logic [30:0]           word;
  logic [31:0]           word_nx;
  logic [4:0]            bit_cnt;
  logic [3:0]            warm_cnt;
  logic [7:0]            rep_cnt;
  logic [7:0]            rep_nx;
  logic                  last_bit;
  logic                  accept;
  logic                  done;
  logic                  trip;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  valid_int;
  logic [SEED_WIDTH-1:0] fifo_head;

  // Bit intake, repetition count and word completion for the current cycle.
  always_comb begin
    accept  = ent_valid && (state != SCARV_COP_RNG_SEED_ST_FAIL);
    rep_nx  = (ent_bit == last_bit) ? rep_cnt + 8'd1 : 8'd1;
    trip    = accept && (rep_nx == REP_MAX);
    done    = word_done(accept, bit_cnt);
    word_nx = {word, ent_bit};
  end

  // Seed channel and FIFO control; a word finishing on a health trip is never stored.
  always_comb begin
    valid_int = !fifo_empty && (state != SCARV_COP_RNG_SEED_ST_FAIL);
    pop       = valid_int && seed.seed_ready;
    push      = (state == SCARV_COP_RNG_SEED_ST_RUN) && done && !trip && (!fifo_full || pop);
    flush     = trip || (state == SCARV_COP_RNG_SEED_ST_FAIL);
  end

  assign seed.seed_valid = valid_int;
  assign seed.seed_data  = valid_int ? fifo_head : 32'h0;
  assign health_fail     = (state == SCARV_COP_RNG_SEED_ST_FAIL);

  // Next-state selection; a health trip takes priority over every other transition.
  always_comb begin
    state_nx = state;
    case (state)
      SCARV_COP_RNG_SEED_ST_WARMUP: begin
        if (trip)                                    state_nx = SCARV_COP_RNG_SEED_ST_FAIL;
        else if (WARMUP_WORDS == 0)                  state_nx = SCARV_COP_RNG_SEED_ST_RUN;
        else if (done && (warm_cnt == WARM_LAST))    state_nx = SCARV_COP_RNG_SEED_ST_RUN;
      end
      SCARV_COP_RNG_SEED_ST_RUN: begin
        if (trip) state_nx = SCARV_COP_RNG_SEED_ST_FAIL;
      end
      SCARV_COP_RNG_SEED_ST_FAIL: begin
        if (health_clr) state_nx = SCARV_COP_RNG_SEED_ST_WARMUP;
      end
      default: state_nx = SCARV_COP_RNG_SEED_ST_WARMUP;
    endcase
  end

  // FSM, packer and health-test state; FAIL holds every counter at zero.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state    <= SCARV_COP_RNG_SEED_ST_WARMUP;
      word     <= '0;
      bit_cnt  <= 5'd0;
      warm_cnt <= 4'd0;
      rep_cnt  <= 8'd0;
      last_bit <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == SCARV_COP_RNG_SEED_ST_FAIL) begin
        word     <= '0;
        bit_cnt  <= 5'd0;
        warm_cnt <= 4'd0;
        rep_cnt  <= 8'd0;
        last_bit <= 1'b0;
      end else if (accept) begin
        word     <= word_nx[30:0];
        bit_cnt  <= bit_cnt + 5'd1;
        rep_cnt  <= rep_nx;
        last_bit <= ent_bit;
        if ((state == SCARV_COP_RNG_SEED_ST_WARMUP) && done) warm_cnt <= warm_cnt + 4'd1;
      end
    end
  end

  scarv_cop_rng_fifo #(
    .WIDTH (SEED_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .din      (word_nx),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_scarv_cop_rng_seeder.sv
// tb/tb_scarv_cop_rng_seeder.sv - scoreboard bench for the RNG seed producer
module tb_scarv_cop_rng_seeder;

  localparam int DEPTH  = 4;
  localparam int REP    = 16;
  localparam int WARM   = 2;
  localparam int M_WARM = 0;
  localparam int M_RUN  = 1;
  localparam int M_FAIL = 2;

  logic       g_clk      = 1'b0;
  logic       g_resetn   = 1'b0;
  logic       ent_valid  = 1'b0;
  logic       ent_bit    = 1'b0;
  logic       health_clr = 1'b0;
  logic       health_fail;
  logic [4:0] fifo_level;

  scarv_cop_rng_seeder_if seed_if ();

  scarv_cop_rng_seeder #(
    .FIFO_DEPTH   (DEPTH),
    .REP_LIMIT    (REP),
    .WARMUP_WORDS (WARM)
  ) dut (
    .g_clk       (g_clk),
    .g_resetn    (g_resetn),
    .ent_valid   (ent_valid),
    .ent_bit     (ent_bit),
    .health_clr  (health_clr),
    .health_fail (health_fail),
    .fifo_level  (fifo_level),
    .seed        (seed_if)
  );

  always #5 g_clk = ~g_clk;

  int tests = 0;
  int fails = 0;

  int          m_mode = M_WARM;
  int          m_bits = 0;
  int          m_run  = 0;
  int          m_last = 0;
  int          m_warm = 0;
  logic [31:0] m_acc  = 32'h0;
  logic [31:0] m_fifo [$];
  logic [31:0] exp_q  [$];

  bit          chk_en    = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_fail  = 1'b0;
  logic [4:0]  exp_level = 5'd0;
  logic [31:0] exp_head  = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  function automatic logic [31:0] safe_word();
    return ($urandom() | 32'h01010101) & ~32'h10101010;
  endfunction

  task automatic model_reset();
    m_mode = M_WARM;
    m_bits = 0;
    m_run  = 0;
    m_last = 0;
    m_warm = 0;
    m_fifo.delete();
  endtask

  task automatic model_step(input logic ev, input logic eb, input logic rdy, input logic clr, input logic rst);
    bit tripped;
    bit done;
    if (!rst) begin
      model_reset();
      return;
    end
    if (rdy && m_fifo.size() > 0 && m_mode != M_FAIL) exp_q.push_back(m_fifo.pop_front());
    if (m_mode == M_FAIL) begin
      if (clr) m_mode = M_WARM;
      return;
    end
    if (ev) begin
      m_run  = (int'(eb) == m_last) ? m_run + 1 : 1;
      m_last = int'(eb);
      m_acc  = {m_acc[30:0], eb};
      m_bits++;
      tripped = (m_run == REP);
      done    = (m_bits == 32);
      if (done) m_bits = 0;
      if (tripped) begin
        m_fifo.delete();
        m_mode = M_FAIL;
        m_bits = 0;
        m_run  = 0;
        m_last = 0;
        m_warm = 0;
        return;
      end
      if (done) begin
        if (m_mode == M_WARM) m_warm++;
        else if (m_fifo.size() < DEPTH) m_fifo.push_back(m_acc);
      end
    end
    if (m_mode == M_WARM && m_warm >= WARM) m_mode = M_RUN;
  endtask

  task automatic drive(input logic ev, input logic eb, input logic rdy, input logic clr, input logic rst);
    exp_valid = (m_fifo.size() > 0) && (m_mode != M_FAIL);
    exp_head  = exp_valid ? m_fifo[0] : 32'h0;
    exp_level = 5'(m_fifo.size());
    exp_fail  = (m_mode == M_FAIL);
    g_resetn           = rst;
    ent_valid          = ev;
    ent_bit            = eb;
    seed_if.seed_ready = rdy;
    health_clr         = clr;
    model_step(ev, eb, rdy, clr, rst);
    @(posedge g_clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic rdy);
    for (int i = 31; i >= 0; i--) drive(1'b1, w[i], rdy, 1'b0, 1'b1);
  endtask

  // Monitor: compares outputs with the model snapshot and consumes expected pops.
  always @(negedge g_clk) begin
    if (chk_en) begin
      chk("seed_valid", 32'(seed_if.seed_valid), 32'(exp_valid));
      chk("seed_data", seed_if.seed_data, exp_head);
      chk("fifo_level", 32'(fifo_level), 32'(exp_level));
      chk("health_fail", 32'(health_fail), 32'(exp_fail));
      if (seed_if.seed_valid && seed_if.seed_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got handshake with data %h, want no pop", seed_if.seed_data);
        end else begin
          chk("pop_word", seed_if.seed_data, exp_q.pop_front());
        end
      end
      if (exp_q.size() != 0) begin
        tests++;
        fails++;
        $display("FAIL pop_missing: got no handshake, want pop of %h", exp_q[0]);
        exp_q.delete();
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [31:0] words [6];
    logic        b;
    bit          sticky;
    logic        ev;
    logic        rdy;
    logic        clr;
    logic        rst;

    seed_if.seed_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_valid", 32'(seed_if.seed_valid), 32'd0);
    chk("reset_data", seed_if.seed_data, 32'h0);
    chk("reset_fail", 32'(health_fail), 32'd0);
    chk("reset_level", 32'(fifo_level), 32'd0);

    // Alternating bits: two warm-up words dropped, third stored.
    for (int i = 0; i < 96; i++) begin
      drive(1'b1, i[0], 1'b0, 1'b0, 1'b1);
      if (i == 94) chk("t1_valid_before", 32'(seed_if.seed_valid), 32'd0);
    end
    chk("t1_valid", 32'(seed_if.seed_valid), 32'd1);
    chk("t1_word", seed_if.seed_data, 32'h55555555);
    chk("t1_level", 32'(fifo_level), 32'd1);
    repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t1_drained", 32'(fifo_level), 32'd0);

    // Six words into a four-deep FIFO with no consumer.
    for (int k = 0; k < 6; k++) begin
      words[k] = safe_word();
      send_word(words[k], 1'b0);
    end
    chk("t2_level_sat", 32'(fifo_level), 32'd4);
    chk("t2_head", seed_if.seed_data, words[0]);
    repeat (6) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t2_drained", 32'(fifo_level), 32'd0);

    // Sixteen consecutive ones mid-word trip the health test.
    send_word(safe_word(), 1'b0);
    chk("t3_level_pre", 32'(fifo_level), 32'd1);
    for (int i = 0; i < 5; i++) drive(1'b1, i[0], 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      if (i == 14) chk("t3_fail_early", 32'(health_fail), 32'd0);
    end
    chk("t3_fail", 32'(health_fail), 32'd1);
    chk("t3_level", 32'(fifo_level), 32'd0);
    chk("t3_valid", 32'(seed_if.seed_valid), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t3_fail_held", 32'(health_fail), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t3_cleared", 32'(health_fail), 32'd0);

    // Full FIFO with a pop on the cycle a new word completes.
    send_word(safe_word(), 1'b0);
    send_word(safe_word(), 1'b0);
    for (int k = 0; k < 4; k++) begin
      words[k] = safe_word();
      send_word(words[k], 1'b0);
    end
    chk("t4_full", 32'(fifo_level), 32'd4);
    w = safe_word();
    for (int i = 31; i >= 0; i--) drive(1'b1, w[i], (i == 0), 1'b0, 1'b1);
    chk("t4_level_kept", 32'(fifo_level), 32'd4);
    chk("t4_new_head", seed_if.seed_data, words[1]);
    repeat (4) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Word completion on the same edge as the health trip.
    send_word(safe_word(), 1'b0);
    send_word(safe_word(), 1'b0);
    w = 32'hAAAAFFFF;
    for (int i = 31; i >= 0; i--) begin
      drive(1'b1, w[i], 1'b0, 1'b0, 1'b1);
      if (i == 1) begin
        chk("t5_fail_early", 32'(health_fail), 32'd0);
        chk("t5_level_pre", 32'(fifo_level), 32'd2);
      end
    end
    chk("t5_fail", 32'(health_fail), 32'd1);
    chk("t5_level", 32'(fifo_level), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of operation.
    send_word(safe_word(), 1'b0);
    send_word(safe_word(), 1'b0);
    for (int k = 0; k < 3; k++) send_word(safe_word(), 1'b0);
    chk("t6_level_pre", 32'(fifo_level), 32'd3);
    w = safe_word();
    for (int i = 31; i >= 15; i--) drive(1'b1, w[i], 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_valid", 32'(seed_if.seed_valid), 32'd0);
    chk("t6_data", seed_if.seed_data, 32'h0);
    chk("t6_level", 32'(fifo_level), 32'd0);
    chk("t6_fail", 32'(health_fail), 32'd0);
    send_word(safe_word(), 1'b0);
    send_word(safe_word(), 1'b0);
    chk("t6_warm_dropped", 32'(fifo_level), 32'd0);
    words[0] = safe_word();
    send_word(words[0], 1'b0);
    chk("t6_first_stored", 32'(fifo_level), 32'd1);
    chk("t6_first_head", seed_if.seed_data, words[0]);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Randomised traffic, alternating noisy and sticky entropy segments.
    b = 1'b0;
    for (int s = 0; s < 20; s++) begin
      sticky = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < 200; c++) begin
        ev  = ($urandom_range(0, 3) != 0);
        if (sticky) b = ($urandom_range(0, 19) == 0) ? ~b : b;
        else        b = 1'($urandom());
        rdy = ($urandom_range(0, 2) == 0);
        clr = ($urandom_range(0, 31) == 0);
        rst = ($urandom_range(0, 499) != 0);
        drive(ev, b, rst ? rdy : 1'b0, clr, rst);
      end
    end
    repeat (8) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
